// File: rtl/frame_row_sched_if.sv
// Bus bundle between the frame row scheduler and its RX RAM, edge filter and TX line buffer.
// master = scheduler side, slave = surrounding datapath.
interface frame_row_sched_if #(
  parameter int IMG_W = 176,
  parameter int IMG_H = 240,
  parameter int PIX_W = 24,
  parameter int RES_W = 8
);
  localparam int AW = $clog2(IMG_W * IMG_H);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic             rx_frame_done;
  logic             rx_oe;
  logic [AW-1:0]    rx_addr;
  logic [PIX_W-1:0] rx_data;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             pix_ready;
  logic             res_valid;
  logic [RES_W-1:0] res_data;
  logic             tx_we;
  logic [CW-1:0]    tx_waddr;
  logic [RES_W-1:0] tx_wdata;
  logic             tx_frame_tick;
  logic             tx_frame_done;
  logic             busy;
  logic [RW-1:0]    row_idx;
  logic             frame_end;
  logic             res_err;

  modport master (
    input  rx_frame_done, rx_data, pix_ready, res_valid, res_data, tx_frame_done,
    output rx_oe, rx_addr, pix_valid, pix_data, tx_we, tx_waddr, tx_wdata,
           tx_frame_tick, busy, row_idx, frame_end, res_err
  );

  modport slave (
    output rx_frame_done, rx_data, pix_ready, res_valid, res_data, tx_frame_done,
    input  rx_oe, rx_addr, pix_valid, pix_data, tx_we, tx_waddr, tx_wdata,
           tx_frame_tick, busy, row_idx, frame_end, res_err
  );
endinterface

// File: rtl/frame_row_sched.sv
// Row scheduler: streams one frame from the RX RAM through the filter into the TX line
// buffer a row at a time, with a 2-entry skid buffer absorbing filter backpressure.
module frame_row_sched #(
  parameter int IMG_W = 176,
  parameter int IMG_H = 240,
  parameter int PIX_W = 24,
  parameter int RES_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  frame_row_sched_if.master bus
);
  localparam int AW = $clog2(IMG_W * IMG_H);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW:0]   ROW_LEN  = (CW+1)'(IMG_W);
  localparam logic [CW:0]   CNT_ONE  = (CW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ROW_RUN, S_TICK, S_WAIT_SET, S_WAIT_CLR, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CW:0]      issue_cnt_q, issue_cnt_d;
  logic [CW:0]      res_cnt_q, res_cnt_d;
  logic             inflight_q;
  logic [PIX_W-1:0] skid_q [2];
  logic             skid_rd_q, skid_wr_q;
  logic [1:0]       skid_occ_q;
  logic             tx_we_q;
  logic [CW-1:0]    tx_waddr_q;
  logic [RES_W-1:0] tx_wdata_q;
  logic             res_err_q;

  logic             issue, push, pop, res_ok, res_bad;
  logic [1:0]       occ_after_pop;

  // Occupancy is counted after this cycle's pop so a steady ready stream sustains 1 pixel/cycle.
  assign push          = inflight_q;
  assign pop           = (skid_occ_q != 2'd0) && bus.pix_ready;
  assign occ_after_pop = skid_occ_q - {1'b0, pop};
  assign issue         = (state_q == S_ROW_RUN) && (issue_cnt_q < ROW_LEN) &&
                         ((occ_after_pop + {1'b0, inflight_q}) < 2'd2);

  assign res_ok  = bus.res_valid && (state_q == S_ROW_RUN) && (res_cnt_q != ROW_LEN);
  assign res_bad = bus.res_valid && !res_ok;

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    row_d       = row_q;
    issue_cnt_d = issue_cnt_q;
    res_cnt_d   = res_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.rx_frame_done) begin
          state_d     = S_ROW_RUN;
          rd_ptr_d    = '0;
          row_d       = '0;
          issue_cnt_d = '0;
          res_cnt_d   = '0;
        end
      end
      S_ROW_RUN: begin
        if (issue) begin
          rd_ptr_d    = rd_ptr_q + PTR_ONE;
          issue_cnt_d = issue_cnt_q + CNT_ONE;
        end
        if (res_ok) res_cnt_d = res_cnt_q + CNT_ONE;
        // The final write lands the cycle res_cnt hits ROW_LEN; the tick follows it.
        if (res_cnt_q == ROW_LEN) state_d = S_TICK;
      end
      S_TICK: state_d = S_WAIT_SET;
      S_WAIT_SET: begin
        if (bus.tx_frame_done) state_d = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        if (!bus.tx_frame_done) begin
          if (row_q == ROW_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_ROW_RUN;
            row_d       = row_q + ROW_ONE;
            issue_cnt_d = '0;
            res_cnt_d   = '0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      row_q       <= '0;
      issue_cnt_q <= '0;
      res_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      skid_q[0]   <= '0;
      skid_q[1]   <= '0;
      skid_rd_q   <= 1'b0;
      skid_wr_q   <= 1'b0;
      skid_occ_q  <= 2'd0;
      tx_we_q     <= 1'b0;
      tx_waddr_q  <= '0;
      tx_wdata_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      row_q       <= row_d;
      issue_cnt_q <= issue_cnt_d;
      res_cnt_q   <= res_cnt_d;
      inflight_q  <= issue;
      if (push) begin
        skid_q[skid_wr_q] <= bus.rx_data;
        skid_wr_q         <= ~skid_wr_q;
      end
      if (pop) skid_rd_q <= ~skid_rd_q;
      skid_occ_q <= skid_occ_q + {1'b0, push} - {1'b0, pop};
      tx_we_q    <= res_ok;
      if (res_ok) begin
        tx_waddr_q <= res_cnt_q[CW-1:0];
        tx_wdata_q <= bus.res_data;
      end
      if (res_bad) res_err_q <= 1'b1;
    end
  end

  assign bus.rx_oe         = issue;
  assign bus.rx_addr       = rd_ptr_q;
  assign bus.pix_valid     = (skid_occ_q != 2'd0);
  assign bus.pix_data      = skid_q[skid_rd_q];
  assign bus.tx_we         = tx_we_q;
  assign bus.tx_waddr      = tx_waddr_q;
  assign bus.tx_wdata      = tx_wdata_q;
  assign bus.tx_frame_tick = (state_q == S_TICK);
  assign bus.busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.row_idx       = row_q;
  assign bus.frame_end     = (state_q == S_DONE);
  assign bus.res_err       = res_err_q;

endmodule

// File: tb/tb_frame_row_sched.sv
// Directed bench for frame_row_sched on a 4x2 image with RAM, filter and TX-drain models.
module tb_frame_row_sched;
  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int PIX_W = 24;
  localparam int RES_W = 8;
  localparam int NPIX  = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  frame_row_sched_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .RES_W(RES_W)) bus ();

  frame_row_sched #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .RES_W(RES_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int a);
    pix = {8'(a + 16), 8'(a * 3), 8'(a + 160)};
  endfunction

  // RX RAM: synchronous read, one-cycle latency
  always_ff @(posedge clk) begin
    if (bus.rx_oe) bus.rx_data <= pix(int'(bus.rx_addr));
  end

  // Filter: returns pix_data[7:0] two cycles after acceptance; inj_v forces a stray result
  logic       f1v = 1'b0, f2v = 1'b0;
  logic [7:0] f1d = 8'h0, f2d = 8'h0;
  logic       inj_v = 1'b0;
  logic [7:0] inj_d = 8'h0;
  always_ff @(posedge clk) begin
    f1v <= bus.pix_valid && bus.pix_ready;
    f1d <= bus.pix_data[7:0];
    f2v <= f1v;
    f2d <= f1d;
  end
  assign bus.res_valid = f2v | inj_v;
  assign bus.res_data  = inj_v ? inj_d : f2d;

  // TX side: raises tx_frame_done 3 cycles after each tick, for hold_len cycles
  int hold_len = 2;
  initial begin
    bus.tx_frame_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_frame_tick === 1'b1) begin
        repeat (3) @(negedge clk);
        bus.tx_frame_done = 1'b1;
        repeat (hold_len) @(negedge clk);
        bus.tx_frame_done = 1'b0;
      end
    end
  end

  // Observation of the DUT outputs, mid-cycle
  int addr_q[$], acc_q[$], wa_q[$], wd_q[$];
  int n_tick = 0, n_fend = 0, n_fend_bad = 0, n_oe_hold = 0, n_oe_over = 0;
  int cyc_n = 0, tick_cyc = 0, gap = -1, occ_m = 0, pop_m;
  bit infl_m = 0, prev_stall = 0, prev_busy = 0, gap_arm = 0;
  logic [23:0] prev_pd = '0;

  always begin
    @(negedge clk);
    #2;
    cyc_n++;
    pop_m = (bus.pix_valid && bus.pix_ready) ? 1 : 0;
    if (prev_stall) begin
      chk("stall_valid", 64'(bus.pix_valid), 64'd1);
      chk("stall_data", 64'(bus.pix_data), 64'(prev_pd));
    end
    chk("skid_valid", 64'(bus.pix_valid), 64'(occ_m != 0));
    if (bus.rx_oe) begin
      addr_q.push_back(int'(bus.rx_addr));
      if (bus.tx_frame_done) n_oe_hold++;
      if (occ_m - pop_m + int'(infl_m) >= 2) n_oe_over++;
      if (gap_arm) begin
        gap     = cyc_n - tick_cyc;
        gap_arm = 0;
      end
    end
    if (pop_m == 1) acc_q.push_back(int'(bus.pix_data));
    if (bus.tx_we) begin
      wa_q.push_back(int'(bus.tx_waddr));
      wd_q.push_back(int'(bus.tx_wdata));
    end
    if (bus.tx_frame_tick) begin
      n_tick++;
      tick_cyc = cyc_n;
      gap_arm  = 1;
    end
    if (bus.frame_end) begin
      n_fend++;
      if (bus.busy !== 1'b0 || !prev_busy) n_fend_bad++;
    end
    prev_pd   = bus.pix_data;
    prev_busy = (bus.busy === 1'b1);
    if (reset === 1'b0) begin
      occ_m = 0; infl_m = 0; prev_stall = 0;
    end else begin
      prev_stall = bus.pix_valid && !bus.pix_ready;
      occ_m      = occ_m + int'(infl_m) - pop_m;
      infl_m     = bus.rx_oe;
    end
  end

  task automatic clr();
    addr_q.delete(); acc_q.delete(); wa_q.delete(); wd_q.delete();
    n_tick = 0; n_fend = 0; n_fend_bad = 0; n_oe_hold = 0; n_oe_over = 0;
    gap = -1; gap_arm = 0;
  endtask

  task automatic chk_rst(input string t);
    chk({t, "_rx_oe"}, 64'(bus.rx_oe), 64'd0);
    chk({t, "_pix_valid"}, 64'(bus.pix_valid), 64'd0);
    chk({t, "_tx_we"}, 64'(bus.tx_we), 64'd0);
    chk({t, "_tick"}, 64'(bus.tx_frame_tick), 64'd0);
    chk({t, "_busy"}, 64'(bus.busy), 64'd0);
    chk({t, "_frame_end"}, 64'(bus.frame_end), 64'd0);
    chk({t, "_res_err"}, 64'(bus.res_err), 64'd0);
    chk({t, "_rx_addr"}, 64'(bus.rx_addr), 64'd0);
    chk({t, "_row_idx"}, 64'(bus.row_idx), 64'd0);
    chk({t, "_tx_waddr"}, 64'(bus.tx_waddr), 64'd0);
    chk({t, "_pix_data"}, 64'(bus.pix_data), 64'd0);
    chk({t, "_tx_wdata"}, 64'(bus.tx_wdata), 64'd0);
  endtask

  task automatic start();
    bus.rx_frame_done = 1'b1;
    @(negedge clk);
    bus.rx_frame_done = 1'b0;
  endtask

  task automatic wait_frame(input bit bp, input bit fifth, input bit dup);
    bit done, injected;
    int nres;
    bit pat [6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    done = 0; injected = 0; nres = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      bus.pix_ready = bp ? pat[k % 6] : 1'b1;
      inj_v = 1'b0;
      if (fifth && nres == IMG_W && !injected) begin
        inj_v = 1'b1; inj_d = 8'h5A; injected = 1;
      end
      bus.rx_frame_done = dup && (k == 12);
      #1;
      if (dup && k == 12) chk("dup_start_busy", 64'(bus.busy), 64'd1);
      if (bus.res_valid && !inj_v) nres++;
      if (bus.frame_end) done = 1;
      @(negedge clk);
    end
    inj_v = 1'b0; bus.rx_frame_done = 1'b0; bus.pix_ready = 1'b1;
    chk("frame_end_seen", 64'(done), 64'd1);
  endtask

  task automatic chk_frame(input string t);
    logic [23:0] p;
    chk({t, "_n_addr"}, 64'(addr_q.size()), 64'(NPIX));
    foreach (addr_q[i]) chk({t, "_rx_addr"}, 64'(addr_q[i]), 64'(i));
    chk({t, "_n_acc"}, 64'(acc_q.size()), 64'(NPIX));
    foreach (acc_q[i]) chk({t, "_pix"}, 64'(acc_q[i]), 64'(pix(i)));
    chk({t, "_n_wr"}, 64'(wa_q.size()), 64'(NPIX));
    foreach (wa_q[i]) begin
      p = pix(i);
      chk({t, "_waddr"}, 64'(wa_q[i]), 64'(i % IMG_W));
      chk({t, "_wdata"}, 64'(wd_q[i]), 64'(p[7:0]));
    end
    chk({t, "_ticks"}, 64'(n_tick), 64'd2);
    chk({t, "_frame_ends"}, 64'(n_fend), 64'd1);
    chk({t, "_busy_at_end"}, 64'(n_fend_bad), 64'd0);
    chk({t, "_oe_during_drain"}, 64'(n_oe_hold), 64'd0);
    chk({t, "_oe_skid_full"}, 64'(n_oe_over), 64'd0);
  endtask

  initial begin
    int nwr;
    reset = 1'b0;
    bus.rx_frame_done = 1'b0;
    bus.pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_rst("rst");
    reset = 1'b1;

    // Plain frame, ready always high
    clr();
    start();
    #1;
    chk("A_busy_c1", 64'(bus.busy), 64'd1);
    chk("A_oe_c1", 64'(bus.rx_oe), 64'd1);
    chk("A_addr_c1", 64'(bus.rx_addr), 64'd0);
    chk("A_pv_c1", 64'(bus.pix_valid), 64'd0);
    @(negedge clk); #1;
    chk("A_pv_c2", 64'(bus.pix_valid), 64'd0);
    chk("A_addr_c2", 64'(bus.rx_addr), 64'd1);
    @(negedge clk); #1;
    chk("A_pv_c3", 64'(bus.pix_valid), 64'd1);
    chk("A_pd_c3", 64'(bus.pix_data), 64'(pix(0)));
    chk("A_oe_c3", 64'(bus.rx_oe), 64'd1);
    wait_frame(0, 0, 0);
    chk_frame("A");
    chk("A_row_gap", 64'(gap), 64'd6);
    chk("A_res_err", 64'(bus.res_err), 64'd0);
    chk("A_busy_after", 64'(bus.busy), 64'd0);

    // Backpressure pattern
    clr();
    start();
    wait_frame(1, 0, 0);
    chk_frame("B");

    // Long drain plus a stray start pulse mid-frame
    hold_len = 10;
    clr();
    start();
    wait_frame(0, 0, 1);
    chk_frame("D");
    chk("D_row_gap", 64'(gap), 64'd14);
    hold_len = 2;
    repeat (3) @(negedge clk);
    #1;
    chk("D_idle_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);

    // Reset mid-row after two results are written
    clr();
    start();
    nwr = 0;
    for (int k = 0; k < 60 && nwr < 2; k++) begin
      #1;
      if (bus.tx_we) nwr++;
      if (nwr < 2) @(negedge clk);
    end
    chk("E_two_writes", 64'(nwr), 64'd2);
    reset = 1'b0;
    @(negedge clk); #1;
    chk_rst("E_mid");
    chk("E_no_tick", 64'(n_tick), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clr();
    start();
    wait_frame(0, 0, 0);
    chk_frame("E");

    // Stray result in IDLE
    clr();
    inj_v = 1'b1; inj_d = 8'hC3;
    @(negedge clk);
    inj_v = 1'b0;
    @(negedge clk); #1;
    chk("C_idle_err", 64'(bus.res_err), 64'd1);
    chk("C_idle_no_we", 64'(wa_q.size()), 64'd0);
    @(negedge clk);
    clr();
    start();
    wait_frame(0, 0, 0);
    chk_frame("C1");
    chk("C1_err_sticky", 64'(bus.res_err), 64'd1);

    // Fifth result in a 4-wide row
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("C_err_cleared", 64'(bus.res_err), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    clr();
    start();
    wait_frame(0, 1, 0);
    chk_frame("C2");
    chk("C2_fifth_err", 64'(bus.res_err), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
